cdb_arbiter: RTL

- Sits directly downstream of the functional units and upstream of the common data bus (CDB) that the reservation stations, register status table and ROB snoop.
- Collects completed FU results into small per-FU FIFOs.
- Grants up to CDB_LANES results per cycle round-robin and drives them onto registered CDB lanes, with backpressure both towards the FUs and from the CDB consumers.

---
 rtl/cdb_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/cdb_arbiter.sv
// Result arbiter feeding the common data bus: per-FU result FIFOs, round-robin
// grant of up to CDB_LANES heads per cycle, registered CDB lanes with backpressure.
`ifndef PHYSICAL_REG_NUM_WIDTH
`define PHYSICAL_REG_NUM_WIDTH 6
`endif
`ifndef REG_VAL_WIDTH
`define REG_VAL_WIDTH 32
`endif
`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 5
`endif

module cdb_arbiter #(
  parameter int FU_NUM     = 4,
  parameter int CDB_LANES  = 2,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [FU_NUM-1:0]                         fu_res_valid,
  output logic [FU_NUM-1:0]                         fu_res_ready,
  input  logic [FU_NUM*`PHYSICAL_REG_NUM_WIDTH-1:0] fu_res_reg_addr,
  input  logic [FU_NUM*`REG_VAL_WIDTH-1:0]          fu_res_reg_val,
  input  logic [FU_NUM*`ROB_SIZE_WIDTH-1:0]         fu_res_tag,
  input  logic [FU_NUM-1:0]                         fu_res_reg_write,
  output logic [CDB_LANES-1:0]                      cdb_valid,
  output logic [CDB_LANES*`PHYSICAL_REG_NUM_WIDTH-1:0] cdb_register_addr,
  output logic [CDB_LANES*`REG_VAL_WIDTH-1:0]       cdb_register_val,
  output logic [CDB_LANES*`ROB_SIZE_WIDTH-1:0]      cdb_tag,
  output logic [CDB_LANES-1:0]                      cdb_reg_write,
  input  logic                                      cdb_ready
);

  localparam int AW    = `PHYSICAL_REG_NUM_WIDTH;
  localparam int VW    = `REG_VAL_WIDTH;
  localparam int TW    = `ROB_SIZE_WIDTH;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int RR_W  = (FU_NUM > 1) ? $clog2(FU_NUM) : 1;
  localparam int SEL_W = $clog2(CDB_LANES + 1);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [VW-1:0] val;
    logic [TW-1:0] tag;
    logic          wr;
  } entry_t;

  entry_t           mem   [FU_NUM][FIFO_DEPTH];
  logic [PTR_W-1:0] head  [FU_NUM];
  logic [PTR_W-1:0] tail  [FU_NUM];
  logic [CNT_W-1:0] count [FU_NUM];
  entry_t           fu_in [FU_NUM];
  entry_t           lane_next [CDB_LANES];
  logic [CDB_LANES-1:0] lane_valid_next;
  logic [FU_NUM-1:0] push;
  logic [FU_NUM-1:0] pop;
  logic [RR_W-1:0]  rr;
  logic [RR_W-1:0]  rr_next;
  logic [RR_W-1:0]  scan_idx;
  logic [SEL_W-1:0] sel_cnt;
  logic             upd;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign upd = cdb_ready | ~|cdb_valid;

  // Ready depends only on registered occupancy, so FUs never see a path from cdb_ready.
  always_comb begin
    fu_res_ready = '0;
    push         = '0;
    for (int f = 0; f < FU_NUM; f++) begin
      fu_res_ready[f] = !reset && (count[f] != CNT_W'(FIFO_DEPTH));
      push[f]         = fu_res_valid[f] && fu_res_ready[f];
      fu_in[f] = {fu_res_reg_addr[f*AW +: AW], fu_res_reg_val[f*VW +: VW],
                  fu_res_tag[f*TW +: TW], fu_res_reg_write[f]};
    end
  end

  // Walk FIFOs starting at rr and hand the first non-empty heads to lanes in order.
  always_comb begin
    pop             = '0;
    rr_next         = rr;
    lane_valid_next = '0;
    sel_cnt         = '0;
    scan_idx        = rr;
    for (int l = 0; l < CDB_LANES; l++) lane_next[l] = '0;
    for (int k = 0; k < FU_NUM; k++) begin
      for (int f = 0; f < FU_NUM; f++) begin
        if (RR_W'(f) == scan_idx && count[f] != '0 && sel_cnt < SEL_W'(CDB_LANES)) begin
          pop[f] = upd;
          for (int l = 0; l < CDB_LANES; l++) begin
            if (SEL_W'(l) == sel_cnt) begin
              lane_valid_next[l] = 1'b1;
              lane_next[l]       = mem[f][head[f]];
            end
          end
          sel_cnt = sel_cnt + 1'b1;
          rr_next = (f == FU_NUM - 1) ? '0 : RR_W'(f + 1);
        end
      end
      scan_idx = (scan_idx == RR_W'(FU_NUM - 1)) ? '0 : scan_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int f = 0; f < FU_NUM; f++) begin
      if (push[f]) mem[f][tail[f]] <= fu_in[f];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr                <= '0;
      cdb_valid         <= '0;
      cdb_register_addr <= '0;
      cdb_register_val  <= '0;
      cdb_tag           <= '0;
      cdb_reg_write     <= '0;
      for (int f = 0; f < FU_NUM; f++) begin
        head[f]  <= '0;
        tail[f]  <= '0;
        count[f] <= '0;
      end
    end else begin
      for (int f = 0; f < FU_NUM; f++) begin
        if (push[f]) tail[f] <= ptr_inc(tail[f]);
        if (pop[f])  head[f] <= ptr_inc(head[f]);
        if (push[f] && !pop[f])      count[f] <= count[f] + 1'b1;
        else if (!push[f] && pop[f]) count[f] <= count[f] - 1'b1;
      end
      if (upd) begin
        rr        <= rr_next;
        cdb_valid <= lane_valid_next;
        for (int l = 0; l < CDB_LANES; l++) begin
          cdb_register_addr[l*AW +: AW] <= lane_next[l].addr;
          cdb_register_val[l*VW +: VW]  <= lane_next[l].val;
          cdb_tag[l*TW +: TW]           <= lane_next[l].tag;
          cdb_reg_write[l]              <= lane_next[l].wr;
        end
      end
    end
  end

endmodule
